// File: rtl/mdu_if.sv
// mdu_if: issue/result bundle between the EX-stage issue logic and the
// multiply/divide unit.
//   start  issue strobe; op/a/b valid in the same cycle
//   op     operation code (MULT, MULTU, DIV, DIVU, MTHI, MTLO, MADD*, MSUB*)
//   a, b   rs / rt operands
//   flush  abort from a later-stage exception
//   busy   operation in flight
//   hi, lo architectural HI/LO registers
// The master modport drives the issue side; the slave modport is the MDU.
interface mdu_if;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, op, a, b, flush, input busy, hi, lo);
  modport slave  (input start, op, a, b, flush, output busy, hi, lo);
endinterface

// File: rtl/mdu_iterative.sv
// mdu_iterative: multi-cycle multiply/divide unit owning HI/LO.
//   clk    rising-edge clock
//   rst    asynchronous active-high reset
//   bus    mdu_if.slave: start/op/a/b/flush in, busy/hi/lo out
// Parameter MUL_LATENCY (1..8): cycles busy stays high for a multiply.
// Divide: restoring radix-2, one quotient bit per cycle, 32 busy cycles.
// Optional feature macro MDU_MADD_EN: enables MADD/MADDU/MSUB/MSUBU
// (ops 6..9) accumulating into {hi,lo}; without it those ops are no-ops.
module mdu_iterative #(
  parameter int unsigned MUL_LATENCY = 3
) (
  input logic  clk,
  input logic  rst,
  mdu_if.slave bus
);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  localparam logic [5:0] MUL_CNT = 6'(MUL_LATENCY);

  state_t      state, state_next;
  logic [5:0]  cnt;
  logic [31:0] a_q, b_q, dvs, quo, rem, hi_q, lo_q;
  logic        mul_sgn, q_neg, r_neg;
`ifdef MDU_MADD_EN
  logic [1:0]  acc_mode;  // 01: add product, 10: subtract product
`endif

  logic        is_mul, is_div, is_mthi, is_mtlo, div_sgn, issue, last;
  logic [32:0] shifted, diff;
  logic [31:0] quo_step, rem_step;
  logic [63:0] ext_a, ext_b, prod, mul_res;

  always_comb begin
    is_mul  = 1'b0;
    is_div  = 1'b0;
    is_mthi = 1'b0;
    is_mtlo = 1'b0;
    case (bus.op)
      4'd0, 4'd1: is_mul = 1'b1;
`ifdef MDU_MADD_EN
      4'd6, 4'd7, 4'd8, 4'd9: is_mul = 1'b1;
`endif
      4'd2, 4'd3: is_div  = 1'b1;
      4'd4:       is_mthi = 1'b1;
      4'd5:       is_mtlo = 1'b1;
      default: ;
    endcase
  end

  assign div_sgn = (bus.op == 4'd2);
  // flush outranks a same-cycle start, including MTHI/MTLO
  assign issue   = bus.start && !bus.flush && (state == IDLE);
  assign last    = (cnt == 6'd1);

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (issue && is_mul)      state_next = MUL;
        else if (issue && is_div) state_next = DIV;
      end
      MUL, DIV: if (bus.flush || last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // One restoring-division step; the remainder always stays below the
  // divisor, so 32 stored bits suffice after the 33-bit trial subtract.
  always_comb begin
    shifted  = {rem, quo[31]};
    diff     = shifted - {1'b0, dvs};
    quo_step = {quo[30:0], ~diff[32]};
    rem_step = diff[32] ? shifted[31:0] : diff[31:0];
  end

  // Sign-extend (or zero-extend) to 64 bits; the low 64 bits of the
  // product are then correct for both signed and unsigned operands.
  always_comb begin
    ext_a = {{32{mul_sgn & a_q[31]}}, a_q};
    ext_b = {{32{mul_sgn & b_q[31]}}, b_q};
    prod  = ext_a * ext_b;
`ifdef MDU_MADD_EN
    case (acc_mode)
      2'b01:   mul_res = {hi_q, lo_q} + prod;
      2'b10:   mul_res = {hi_q, lo_q} - prod;
      default: mul_res = prod;
    endcase
`else
    mul_res = prod;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      dvs      <= '0;
      quo      <= '0;
      rem      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      mul_sgn  <= 1'b0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
`ifdef MDU_MADD_EN
      acc_mode <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (issue) begin
          if (is_mthi) hi_q <= bus.a;
          if (is_mtlo) lo_q <= bus.a;
          if (is_mul) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            mul_sgn <= ~bus.op[0];
            cnt     <= MUL_CNT;
`ifdef MDU_MADD_EN
            acc_mode <= (bus.op == 4'd6 || bus.op == 4'd7) ? 2'b01 :
                        (bus.op == 4'd8 || bus.op == 4'd9) ? 2'b10 : 2'b00;
`endif
          end
          if (is_div) begin
            a_q   <= bus.a;
            dvs   <= (div_sgn && bus.b[31]) ? -bus.b : bus.b;
            quo   <= (div_sgn && bus.a[31]) ? -bus.a : bus.a;
            rem   <= '0;
            q_neg <= div_sgn & (bus.a[31] ^ bus.b[31]);
            r_neg <= div_sgn & bus.a[31];
            cnt   <= 6'd32;
          end
        end
        MUL: if (!bus.flush) begin
          cnt <= cnt - 6'd1;
          if (last) {hi_q, lo_q} <= mul_res;
        end
        DIV: if (!bus.flush) begin
          cnt <= cnt - 6'd1;
          quo <= quo_step;
          rem <= rem_step;
          if (last) begin
            if (dvs == '0) begin
              lo_q <= '1;
              hi_q <= a_q;
            end else begin
              lo_q <= q_neg ? -quo_step : quo_step;
              hi_q <= r_neg ? -rem_step : rem_step;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// tb_mdu_iterative: directed self-checking bench for mdu_iterative
// (MUL_LATENCY = 3). Outputs are sampled 1 time unit after the rising edge.
module tb_mdu_iterative;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n;

  mdu_if bus ();

  mdu_iterative #(.MUL_LATENCY(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents start for one cycle; returns 1 unit after edge 0 (in cycle 1).
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    step();
    bus.start = 1'b0;
  endtask

  // Counts remaining busy cycles, bounded.
  task automatic wait_done(output int cycles);
    cycles = 0;
    while (bus.busy === 1'b1 && cycles < 100) begin
      cycles++;
      step();
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op    = '0;
    bus.a     = '0;
    bus.b     = '0;
    bus.flush = 1'b0;
    #12;
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_hi", bus.hi, 32'h0);
    chk("reset_lo", bus.lo, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // MULT -2 * 3
    issue(4'd0, 32'hFFFF_FFFE, 32'd3);
    chk("mult_hi_stable", bus.hi, 32'h0);
    wait_done(n);
    chk("mult_busy_cycles", 32'(n), 32'd3);
    chk("mult_hi", bus.hi, 32'hFFFF_FFFF);
    chk("mult_lo", bus.lo, 32'hFFFF_FFFA);

    // MULTU same operands
    issue(4'd1, 32'hFFFF_FFFE, 32'd3);
    wait_done(n);
    chk("multu_busy_cycles", 32'(n), 32'd3);
    chk("multu_hi", bus.hi, 32'h0000_0002);
    chk("multu_lo", bus.lo, 32'hFFFF_FFFA);

    // -1 * -1 signed vs unsigned
    issue(4'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(n);
    chk("mult_m1_hi", bus.hi, 32'h0);
    chk("mult_m1_lo", bus.lo, 32'h1);
    issue(4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(n);
    chk("multu_max_hi", bus.hi, 32'hFFFF_FFFE);
    chk("multu_max_lo", bus.lo, 32'h1);

    // DIV -7 / 2
    issue(4'd2, 32'hFFFF_FFF9, 32'd2);
    wait_done(n);
    chk("div_busy_cycles", 32'(n), 32'd32);
    chk("div_lo", bus.lo, 32'hFFFF_FFFD);
    chk("div_hi", bus.hi, 32'hFFFF_FFFF);

    // Divide by zero, unsigned and signed
    issue(4'd3, 32'd7, 32'd0);
    wait_done(n);
    chk("divu0_lo", bus.lo, 32'hFFFF_FFFF);
    chk("divu0_hi", bus.hi, 32'd7);
    issue(4'd2, 32'hFFFF_FFFB, 32'd0);
    wait_done(n);
    chk("div0_lo", bus.lo, 32'hFFFF_FFFF);
    chk("div0_hi", bus.hi, 32'hFFFF_FFFB);

    // Signed overflow case
    issue(4'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(n);
    chk("divovf_busy_cycles", 32'(n), 32'd32);
    chk("divovf_lo", bus.lo, 32'h8000_0000);
    chk("divovf_hi", bus.hi, 32'h0);

    // MTHI / MTLO
    issue(4'd4, 32'd5, 32'd0);
    chk("mthi_busy", 32'(bus.busy), 32'd0);
    chk("mthi_hi", bus.hi, 32'd5);
    issue(4'd5, 32'd6, 32'd0);
    chk("mtlo_lo", bus.lo, 32'd6);
    chk("mtlo_hi_kept", bus.hi, 32'd5);

    // DIVU 100/7 flushed at cycle 10
    issue(4'd3, 32'd100, 32'd7);
    repeat (9) step();
    @(negedge clk);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("flush_busy", 32'(bus.busy), 32'd0);
    chk("flush_hi", bus.hi, 32'd5);
    chk("flush_lo", bus.lo, 32'd6);

    issue(4'd3, 32'd100, 32'd7);
    wait_done(n);
    chk("divu_lo", bus.lo, 32'd14);
    chk("divu_hi", bus.hi, 32'd2);

    // MULT issued during DIV busy is ignored
    issue(4'd3, 32'd50, 32'd8);
    step();
    step();
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 4'd0;
    bus.a     = 32'd3;
    bus.b     = 32'd3;
    step();
    bus.start = 1'b0;
    wait_done(n);
    chk("ignored_busy_cycles", 32'(n), 32'd29);
    chk("ignored_lo", bus.lo, 32'd6);
    chk("ignored_hi", bus.hi, 32'd2);
    step();
    chk("ignored_no_mul_busy", 32'(bus.busy), 32'd0);

    // flush beats a same-cycle MTHI
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 4'd4;
    bus.a     = 32'hDEAD_BEEF;
    bus.flush = 1'b1;
    step();
    bus.start = 1'b0;
    bus.flush = 1'b0;
    chk("flush_start_hi", bus.hi, 32'd2);

    // flush in the commit cycle of a multiply
    issue(4'd1, 32'd3, 32'd3);
    step();
    step();
    @(negedge clk);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("flush_commit_busy", 32'(bus.busy), 32'd0);
    chk("flush_commit_hi", bus.hi, 32'd2);
    chk("flush_commit_lo", bus.lo, 32'd6);

`ifdef MDU_MADD_EN
    issue(4'd4, 32'h0, 32'd0);
    issue(4'd5, 32'hFFFF_FFFF, 32'd0);
    issue(4'd7, 32'd1, 32'd1);
    wait_done(n);
    chk("maddu_busy_cycles", 32'(n), 32'd3);
    chk("maddu_hi", bus.hi, 32'd1);
    chk("maddu_lo", bus.lo, 32'h0);
    issue(4'd8, 32'd1, 32'd1);
    wait_done(n);
    chk("msub_hi", bus.hi, 32'h0);
    chk("msub_lo", bus.lo, 32'hFFFF_FFFF);
`else
    issue(4'd6, 32'd1, 32'd1);
    chk("madd_off_busy", 32'(bus.busy), 32'd0);
    step();
    chk("madd_off_hi", bus.hi, 32'd2);
    chk("madd_off_lo", bus.lo, 32'd6);
`endif

    // Async reset at cycle 5 of a DIV
    issue(4'd2, 32'd100, 32'd3);
    repeat (4) step();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_busy", 32'(bus.busy), 32'd0);
    chk("rst_mid_hi", bus.hi, 32'h0);
    chk("rst_mid_lo", bus.lo, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (35) step();
    chk("rst_no_commit_lo", bus.lo, 32'h0);

    issue(4'd0, 32'd7, 32'hFFFF_FFFF);
    wait_done(n);
    chk("post_rst_hi", bus.hi, 32'hFFFF_FFFF);
    chk("post_rst_lo", bus.lo, 32'hFFFF_FFF9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
